sata_host_cmd_seq: RTL

SATA_HOST_CMD_SEQ -- requirements
Module: sata_host_cmd_seq

---
 rtl/sata_host_cmd_seq_pkg.sv | 42 ++++
 rtl/sata_host_cmd_seq_if.sv | 34 +++
 rtl/sata_timeout_cnt.sv | 28 ++
 rtl/sata_host_cmd_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sata_host_cmd_seq_pkg.sv
// Shared definitions for the SATA host command sequencer: FSM states,
// shadow-register addresses, completion codes and ATA status bit positions.
package sata_host_cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REG,
    WAIT_IPF,
    RD_STAT,
    CAPT,
    FIN
  } state_t;

  localparam logic [4:0] REG_FEATURES = 5'h01;
  localparam logic [4:0] REG_COUNT    = 5'h02;
  localparam logic [4:0] REG_LBA_LO   = 5'h03;
  localparam logic [4:0] REG_LBA_MID  = 5'h04;
  localparam logic [4:0] REG_LBA_HI   = 5'h05;
  localparam logic [4:0] REG_DEVICE   = 5'h06;
  localparam logic [4:0] REG_COMMAND  = 5'h07;
  localparam logic [4:0] REG_STATUS   = 5'h07;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DEV     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LINK    = 2'd3;

  localparam int STS_ERR  = 0;
  localparam int STS_DRQ  = 3;
  localparam int STS_DF   = 5;
  localparam int STS_DRDY = 6;
  localparam int STS_BSY  = 7;

  // Index of the command-register write, the last of the seven.
  localparam logic [2:0] LAST_WR_IDX = 3'd6;

  // Writes go out in address order starting at the features register.
  function automatic logic [4:0] reg_addr(input logic [2:0] idx);
    return 5'(idx) + REG_FEATURES;
  endfunction

endpackage

// File: rtl/sata_host_cmd_seq_if.sv
// Command request/completion and shadow-register bus between the sequencer
// (master) and the command source / SATA top (slave).
interface sata_host_cmd_seq_if;
  logic        LINKUP;
  logic        CMD_START;
  logic [7:0]  CMD_OPCODE;
  logic [15:0] CMD_FEATURES;
  logic [47:0] CMD_LBA;
  logic [15:0] CMD_COUNT;
  logic        HOST_WRITE_EN;
  logic        HOST_READ_EN;
  logic [4:0]  HOST_ADDR_REG;
  logic [31:0] HOST_WDATA;
  logic [31:0] HOST_RDATA;
  logic        IPF;
  logic        CMD_BUSY;
  logic        CMD_DONE;
  logic [1:0]  CMD_ERR;
  logic [7:0]  CMD_STATUS;

  modport master (
    input  LINKUP, CMD_START, CMD_OPCODE, CMD_FEATURES, CMD_LBA, CMD_COUNT,
    input  HOST_RDATA, IPF,
    output HOST_WRITE_EN, HOST_READ_EN, HOST_ADDR_REG, HOST_WDATA,
    output CMD_BUSY, CMD_DONE, CMD_ERR, CMD_STATUS
  );

  modport slave (
    output LINKUP, CMD_START, CMD_OPCODE, CMD_FEATURES, CMD_LBA, CMD_COUNT,
    output HOST_RDATA, IPF,
    input  HOST_WRITE_EN, HOST_READ_EN, HOST_ADDR_REG, HOST_WDATA,
    input  CMD_BUSY, CMD_DONE, CMD_ERR, CMD_STATUS
  );
endinterface

// File: rtl/sata_timeout_cnt.sv
// Saturating wait counter: cleared by clr, advances while en, and flags
// terminal count when it reaches TC_VAL.
module sata_timeout_cnt #(
  parameter int            W      = 24,
  parameter logic [W-1:0]  TC_VAL = {W{1'b1}}
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/sata_host_cmd_seq.sv
// Host-side ATA command sequencer: loads the shadow registers, waits for the
// device interrupt, reads back status and reports completion.
module sata_host_cmd_seq
  import sata_host_cmd_seq_pkg::*;
#(
  parameter int         TIMEOUT_W = 24,
  parameter logic [7:0] DEV_REG   = 8'h40
) (
  input  logic                 CLK,
  input  logic                 RESET,
  sata_host_cmd_seq_if.master  bus
);

  // FIN and the registered done pulse follow terminal count, so stopping two
  // short makes WAIT_IPF entry to CMD_DONE span 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] TC_VAL = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(2);

  state_t      state_q, state_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  status_q, status_d;

  logic        latch_cmd;
  logic [7:0]  op_q;
  logic [15:0] feat_q;
  logic [47:0] lba_q;
  logic [15:0] cnt_q;

  logic        cnt_en, cnt_clr, cnt_tc;
  logic        unused_rdata;

  function automatic logic [31:0] wr_word(
    input logic [2:0]  idx,
    input logic [7:0]  op,
    input logic [15:0] feat,
    input logic [47:0] lba,
    input logic [15:0] cnt
  );
    logic [31:0] w;
    w = '0;
    case (idx)
      3'd0:    w = {16'h0, feat};
      3'd1:    w = {16'h0, cnt};
      3'd2:    w = {16'h0, lba[31:24], lba[7:0]};
      3'd3:    w = {16'h0, lba[39:32], lba[15:8]};
      3'd4:    w = {16'h0, lba[47:40], lba[23:16]};
      3'd5:    w = {24'h0, DEV_REG};
      default: w = {24'h0, op};
    endcase
    return w;
  endfunction

  sata_timeout_cnt #(
    .W      (TIMEOUT_W),
    .TC_VAL (TC_VAL)
  ) u_timeout (
    .clk (CLK),
    .rst (RESET),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tc  (cnt_tc)
  );

  assign cnt_en  = (state_q == WAIT_IPF);
  assign cnt_clr = (state_q != WAIT_IPF);

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    status_d  = status_q;
    latch_cmd = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.CMD_START) begin
          if (bus.LINKUP) begin
            // First write leaves straight from the request inputs.
            latch_cmd = 1'b1;
            busy_d    = 1'b1;
            err_d     = ERR_OK;
            wr_idx_d  = '0;
            we_d      = 1'b1;
            addr_d    = REG_FEATURES;
            wdata_d   = wr_word(3'd0, bus.CMD_OPCODE, bus.CMD_FEATURES,
                                bus.CMD_LBA, bus.CMD_COUNT);
            state_d   = WR_REG;
          end else begin
            err_d   = ERR_LINK;
            state_d = FIN;
          end
        end
      end

      WR_REG: begin
        if (!bus.LINKUP) begin
          err_d   = ERR_LINK;
          state_d = FIN;
        end else if (wr_idx_q == LAST_WR_IDX) begin
          state_d = WAIT_IPF;
        end else begin
          wr_idx_d = wr_idx_q + 3'd1;
          we_d     = 1'b1;
          addr_d   = reg_addr(wr_idx_q + 3'd1);
          wdata_d  = wr_word(wr_idx_q + 3'd1, op_q, feat_q, lba_q, cnt_q);
        end
      end

      WAIT_IPF: begin
        if (!bus.LINKUP) begin
          err_d   = ERR_LINK;
          state_d = FIN;
        end else if (bus.IPF) begin
          re_d    = 1'b1;
          addr_d  = REG_STATUS;
          state_d = RD_STAT;
        end else if (cnt_tc) begin
          err_d   = ERR_TIMEOUT;
          state_d = FIN;
        end
      end

      RD_STAT: begin
        if (!bus.LINKUP) begin
          err_d   = ERR_LINK;
          state_d = FIN;
        end else begin
          state_d = CAPT;
        end
      end

      CAPT: begin
        status_d = bus.HOST_RDATA[7:0];
        err_d    = bus.HOST_RDATA[STS_ERR] ? ERR_DEV : ERR_OK;
        state_d  = FIN;
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  // Command fields only matter while busy, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (latch_cmd) begin
      op_q   <= bus.CMD_OPCODE;
      feat_q <= bus.CMD_FEATURES;
      lba_q  <= bus.CMD_LBA;
      cnt_q  <= bus.CMD_COUNT;
    end
  end

  assign unused_rdata = ^bus.HOST_RDATA[31:8];

  assign bus.HOST_WRITE_EN = we_q;
  assign bus.HOST_READ_EN  = re_q;
  assign bus.HOST_ADDR_REG = addr_q;
  assign bus.HOST_WDATA    = wdata_q;
  assign bus.CMD_BUSY      = busy_q;
  assign bus.CMD_DONE      = done_q;
  assign bus.CMD_ERR       = err_q;
  assign bus.CMD_STATUS    = status_q;

endmodule
